elevator_car_model: RTL



---
 rtl/elevator_car_model_pkg.sv | 11 +
 rtl/elevator_car_model_car_timer.sv | 27 ++
 rtl/elevator_car_model.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/elevator_car_model_pkg.sv
// Shared constants and state type for the elevator car plant model.
package elevator_car_model_pkg;

  localparam int unsigned NUM_FLOORS       = 8;
  localparam int unsigned LOC_W            = 3;
  localparam int unsigned FLOOR_TRAVEL_DEF = 8;
  localparam int unsigned DOOR_OPEN_DEF    = 4;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} car_state_e;

endpackage

// File: rtl/elevator_car_model_car_timer.sv
// Loadable down-counter that holds at zero; done flags a zero count.
module car_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elevator_car_model.sv
// Single elevator car plant: timed floor travel and door cycles driven by up/down/stop.
// Optional door_obstruct input is enabled by defining ELEVATOR_CAR_OBSTRUCT_EN.
module elevator_car_model #(
  parameter int unsigned NUM_FLOORS          = elevator_car_model_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_TRAVEL_CYCLES = elevator_car_model_pkg::FLOOR_TRAVEL_DEF,
  parameter int unsigned DOOR_OPEN_CYCLES    = elevator_car_model_pkg::DOOR_OPEN_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   up,
  input  logic                                   down,
  input  logic                                   stop,
  output logic [elevator_car_model_pkg::LOC_W-1:0] location,
  output logic                                   door_status,
  output logic                                   moving,
  output logic                                   floor_arrive,
  output logic                                   cmd_error
`ifdef ELEVATOR_CAR_OBSTRUCT_EN
  ,
  input  logic                                   door_obstruct
`endif
);

  import elevator_car_model_pkg::*;

  localparam int unsigned TW = $clog2(FLOOR_TRAVEL_CYCLES + 1);
  localparam int unsigned DW = $clog2(DOOR_OPEN_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_RELOAD = TW'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_RELOAD   = DW'(DOOR_OPEN_CYCLES - 1);
  localparam logic [LOC_W-1:0] TOP      = LOC_W'(NUM_FLOORS - 1);
  localparam logic [LOC_W-1:0] NEAR_TOP = LOC_W'(NUM_FLOORS - 2);
  localparam logic [LOC_W-1:0] NEAR_BOT = LOC_W'(1);

  car_state_e state;
  logic       stop_pending;
  logic       obstruct, hold_open, stop_now;
  logic       start_up, start_down, cont_up, cont_down;
  logic       travel_load, travel_en, travel_done;
  logic       door_load, door_en, door_done;

`ifdef ELEVATOR_CAR_OBSTRUCT_EN
  assign obstruct = door_obstruct;
`else
  assign obstruct = 1'b0;
`endif

  assign hold_open  = stop | obstruct;
  assign stop_now   = stop | stop_pending;
  assign start_up   = ~stop & up & ~down & (location != TOP);
  assign start_down = ~stop & down & ~up & (location != '0);
  // Continue decisions look at the floor about to be reached.
  assign cont_up    = ~stop_now & up & (location != NEAR_TOP);
  assign cont_down  = ~stop_now & down & (location != NEAR_BOT);

  always_comb begin
    travel_load = 1'b0;
    travel_en   = 1'b0;
    door_load   = 1'b0;
    door_en     = 1'b0;
    case (state)
      IDLE: begin
        door_load   = stop;
        travel_load = start_up | start_down;
      end
      MOVE_UP, MOVE_DOWN: begin
        travel_en   = ~travel_done;
        travel_load = travel_done & ((state == MOVE_UP) ? cont_up : cont_down);
        door_load   = travel_done & stop_now;
      end
      DOOR_OPEN: begin
        door_load = hold_open;
        door_en   = ~hold_open;
      end
      default: ;
    endcase
  end

  car_timer #(.W(TW)) u_travel_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (travel_load),
    .load_val (TRAVEL_RELOAD),
    .en       (travel_en),
    .done     (travel_done)
  );

  car_timer #(.W(DW)) u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (door_load),
    .load_val (DOOR_RELOAD),
    .en       (door_en),
    .done     (door_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      location     <= '0;
      door_status  <= 1'b1;
      moving       <= 1'b0;
      floor_arrive <= 1'b0;
      cmd_error    <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      floor_arrive <= 1'b0;
      cmd_error    <= 1'b0;
      case (state)
        IDLE: begin
          if (stop) begin
            state       <= DOOR_OPEN;
            door_status <= 1'b0;
          end else if (start_up) begin
            state  <= MOVE_UP;
            moving <= 1'b1;
          end else if (start_down) begin
            state  <= MOVE_DOWN;
            moving <= 1'b1;
          end else begin
            cmd_error <= up | down;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          cmd_error <= ~stop & ((state == MOVE_UP) ? down : up);
          if (!travel_done) begin
            if (stop) stop_pending <= 1'b1;
          end else begin
            location     <= (state == MOVE_UP) ? location + 1'b1 : location - 1'b1;
            floor_arrive <= 1'b1;
            stop_pending <= 1'b0;
            if (stop_now) begin
              state       <= DOOR_OPEN;
              door_status <= 1'b0;
              moving      <= 1'b0;
            end else if (!((state == MOVE_UP) ? cont_up : cont_down)) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end
        end
        DOOR_OPEN: begin
          cmd_error <= up | down;
          if (!hold_open && door_done) begin
            state       <= IDLE;
            door_status <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
